duty_ramp: RTL
==============

// Module: duty_ramp
// PURPOSE
// - Upstream stage for the PWM generator. Accepts a target duty over a valid/ready handshake.
// - Ramps its registered duty output toward that target by a fixed step every DIV_CYCLES clocks.
// - Produces smooth LED fades without abrupt brightness jumps.
// - The duty output connects directly to the PWM duty input. Both blocks share clk and WIDTH.
// PARAMETERS
// - WIDTH       8     duty resolution in bits; must match the downstream PWM
// - STEP        1     duty increment/decrement per ramp tick; legal range 1..2**WIDTH-1
// - DIV_CYCLES  1024  clocks between ramp ticks; must be >= 1
// PORTS
// - clk           in   1      system clock; all logic on posedge
// - rst_n         in   1      asynchronous active-low reset
// - target        in   WIDTH  requested final duty
// - target_valid  in   1      target presented
// - target_ready  out  1      block can accept a target (high only in IDLE)
// - duty          out  WIDTH  current duty, registered; connect to PWM duty
// - busy          out  1      ramp in progress (state != IDLE)
// - done          out  1      one-cycle pulse when duty reaches target
// BEHAVIOUR
// - Reset: one clock, clk. Reset is asynchronous and active-low (rst_n). While rst_n=0:
//   duty=0, state=IDLE, target_ready=1, busy=0, done=0, prescaler=0, stored target=0.
// - Accept: transfer occurs on a posedge with target_valid && target_ready.
//   - target is latched and the prescaler is cleared to 0.
//   - target > duty: go to RAMP_UP. target < duty: go to RAMP_DOWN.
//   - target == duty: stay in IDLE; done=1 in the next cycle; duty unchanged.
// - States: IDLE -> RAMP_UP | RAMP_DOWN -> IDLE. No other states.
//   - target_ready = (state==IDLE). busy = !target_ready.
// - Prescaler: counts 0..DIV_CYCLES-1 while ramping. tick = (prescaler==DIV_CYCLES-1).
//   - Wraps to 0 after tick.
//   - The first duty change occurs DIV_CYCLES cycles after the accept edge.
// - RAMP_UP tick: duty <= (target-duty <= STEP) ? target : duty+STEP.
// - RAMP_DOWN tick: duty <= (duty-target <= STEP) ? target : duty-STEP.
//   - Compute the differences at WIDTH bits; they never go negative within a state.
//   - duty never overshoots the target and never wraps past 0 or 2**WIDTH-1.
// - Completion: on the edge where duty is loaded with target, also register done<=1 and state<=IDLE.
//   - done is high for exactly one cycle; target_ready rises in that same cycle.
//   - A new target may be accepted in the cycle done is high.
// - Ramp length: ceil(|target-duty_start|/STEP) ticks.
// - target_valid while busy is ignored, not queued. The upstream source holds valid until ready.
// - Reset mid-ramp: all state returns to reset values immediately; the ramp is abandoned and no done pulse occurs.
// CONFIGURATION
// - Macro DUTY_RAMP_PERIOD_SYNC_EN.
// - Defined:
//   - An internal WIDTH-bit phase counter resets to 0 and free-runs, tracking the PWM counter phase.
//   - The ramp value is computed as above in an internal register.
//   - The duty port is a shadow register loaded only in cycles where phase == 2**WIDTH-1.
//     The new duty therefore takes effect at a PWM period boundary.
//   - done and the return to IDLE are asserted only when the shadow duty equals target.
//   - target==duty on accept still gives done the next cycle.
// - Undefined: there is no phase counter; duty is the ramp register itself (timing above).
// TESTING (WIDTH=8, STEP=4, DIV_CYCLES=2, macro undefined unless noted)
// - Reset: rst_n low -> duty=0, target_ready=1, busy=0, done=0; release with no valid -> outputs stay put.
// - Ramp up: accept target=10 from 0 -> duty 4,8,10 at 2,4,6 cycles after accept;
//   done pulses 1 cycle with duty=10; ready=1.
// - Ramp down and no-op: target=0 from 10 -> duty 6,2,0, then done.
//   Then target=0 again -> done the next cycle, busy never high.
// - Saturation: from 250, target=255 -> duty 254 then 255, no wrap.
//   From 3, target=0 -> 0 in one tick.
// - Busy/reset: valid target=100 while ramping to 200 -> not accepted, ramp continues;
//   drop rst_n mid-ramp -> duty=0 asynchronously, no done.
// - Macro defined: target=8 from 0 -> duty port changes only on cycles after phase==255; done coincides with duty=8.

Source files
------------

// File: rtl/duty_ramp_if.sv
// ----------------------------------------------------------------------------
// duty_ramp_if
// Target handshake plus duty/status outputs of the duty_ramp block.
// The master (upstream source) presents target/target_valid. The slave
// (duty_ramp) returns target_ready, the current duty, busy and done.
// ----------------------------------------------------------------------------
interface duty_ramp_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] target;
  logic             target_valid;
  logic             target_ready;
  logic [WIDTH-1:0] duty;
  logic             busy;
  logic             done;

  modport master (
    output target,
    output target_valid,
    input  target_ready,
    input  duty,
    input  busy,
    input  done
  );

  modport slave (
    input  target,
    input  target_valid,
    output target_ready,
    output duty,
    output busy,
    output done
  );
endinterface : duty_ramp_if

// File: rtl/duty_ramp.sv
// ----------------------------------------------------------------------------
// duty_ramp
// Ramps a registered duty value toward a requested target by STEP every
// DIV_CYCLES clocks, so the downstream PWM fades smoothly instead of jumping.
// A target is accepted over a valid/ready handshake only while idle; done
// pulses for one cycle when the duty lands exactly on the target.
//
// Optional feature, macro DUTY_RAMP_PERIOD_SYNC_EN:
//   A free-running WIDTH-bit phase counter mirrors the PWM counter. The ramp
//   value lives in an internal register and the duty port is a shadow copy
//   refreshed only when phase is at its last count, so duty changes land on
//   PWM period boundaries. Completion then waits for the shadow to match.
// ----------------------------------------------------------------------------
module duty_ramp #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 1,
  parameter int DIV_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  duty_ramp_if.slave   bus
);

  // Prescaler needs at least one bit even when DIV_CYCLES == 1.
  localparam int                PW         = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV_CYCLES - 1);
  localparam logic [WIDTH-1:0]  STEP_W     = WIDTH'(STEP);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_RAMP_DOWN = 2'd2
  } state_t;

  // Registered state
  state_t           r_state;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_ramp;
  logic [PW-1:0]    r_presc;
  logic             r_done;

  // Next-state and helper nets
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_target_nxt;
  logic [WIDTH-1:0] w_ramp_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_done_nxt;

  logic             w_idle;
  logic             w_tick;
  logic [WIDTH-1:0] w_diff_up;
  logic [WIDTH-1:0] w_diff_dn;
  logic             w_last_up;
  logic             w_last_dn;
  logic             w_finish_up;
  logic             w_finish_dn;

  assign w_idle = (r_state == S_IDLE);
  assign w_tick = (r_presc == PRESC_LAST);

  // Differences are only meaningful in their own ramp direction, where the
  // target is on the correct side of the ramp value, so they never go negative.
  assign w_diff_up = r_target - r_ramp;
  assign w_diff_dn = r_ramp - r_target;
  assign w_last_up = (w_diff_up <= STEP_W);
  assign w_last_dn = (w_diff_dn <= STEP_W);

`ifdef DUTY_RAMP_PERIOD_SYNC_EN
  logic [WIDTH-1:0] r_phase;
  logic [WIDTH-1:0] r_duty;
  logic             w_shadow_load;

  assign w_shadow_load = (r_phase == '1);

  // Completion is declared when the shadow (the visible duty) takes the
  // target value, not when the internal ramp first reaches it.
  assign w_finish_up = w_shadow_load && (r_ramp == r_target);
  assign w_finish_dn = w_shadow_load && (r_ramp == r_target);

  // Phase counter free-runs to track the PWM period; shadow duty refreshes
  // only at the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_duty  <= '0;
    end else begin
      r_phase <= r_phase + WIDTH'(1);
      if (w_shadow_load) begin
        r_duty <= r_ramp;
      end
    end
  end

  assign bus.duty = r_duty;
`else
  // Without period sync, the final tick that loads the target is the finish.
  assign w_finish_up = w_tick && w_last_up;
  assign w_finish_dn = w_tick && w_last_dn;

  assign bus.duty = r_ramp;
`endif

  // State, target, ramp value, prescaler and done pulse registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_ramp   <= '0;
      r_presc  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_ramp   <= w_ramp_nxt;
      r_presc  <= w_presc_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state logic: accept in IDLE, step on each prescaler tick while
  // ramping, return to IDLE with a done pulse when the target is reached.
  // NOTE: every signal driven here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_ramp_nxt   = r_ramp;
    w_presc_nxt  = r_presc;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.target_valid) begin
          w_target_nxt = bus.target;
          w_presc_nxt  = '0;
          if (bus.target > r_ramp) begin
            w_state_nxt = S_RAMP_UP;
          end else if (bus.target < r_ramp) begin
            w_state_nxt = S_RAMP_DOWN;
          end else begin
            // Already there: stay idle and report completion next cycle.
            w_done_nxt = 1'b1;
          end
        end
      end

      S_RAMP_UP: begin
        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          w_ramp_nxt = w_last_up ? r_target : r_ramp + STEP_W;
        end
        if (w_finish_up) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end

      S_RAMP_DOWN: begin
        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          w_ramp_nxt = w_last_dn ? r_target : r_ramp - STEP_W;
        end
        if (w_finish_dn) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.target_ready = w_idle;
  assign bus.busy         = !w_idle;
  assign bus.done         = r_done;

endmodule : duty_ramp
